// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop rx synchronizer, mid-bit sampling FSM and a small
// receive FIFO with valid/ready handshake, framing-error and overrun pulses.
module uart_rx #(
    parameter int CDIV        = 10,
    parameter int BUFFER_SIZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       ferr,
    output logic       ovr
);

    localparam int CW = (CDIV > 2) ? $clog2(CDIV) : 1;
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CDIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CDIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic [PW-1:0]   rp;
    logic [PW-1:0]   wp;
    logic [7:0]      mem [BUFFER_SIZE];

    logic            stop_fire;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // Two-flop synchronizer; idles high so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FIFO status and handshake decode, all from registered state
    always_comb begin
        empty     = (rp == wp);
        full      = (rp[AW-1:0] == wp[AW-1:0]) && (rp[AW] != wp[AW]);
        stop_fire = (state == STOP) && (cnt == {CW{1'b0}});
        push      = stop_fire && rx_s && !full;
        pop       = !empty && ready;
        valid     = !empty;
        data      = mem[rp[AW-1:0]];
    end

    // Receive FSM: bit-time counter, data index, shift register, error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= {CW{1'b0}};
            idx   <= 3'd0;
            shreg <= 8'd0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            ferr <= stop_fire && !rx_s;
            ovr  <= stop_fire && rx_s && full;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= HALF_LOAD;
                    end else begin
                        cnt <= {CW{1'b0}};
                    end
                end
                START: begin
                    if (cnt == {CW{1'b0}}) begin
                        // A line back high at mid-start is a glitch, not a frame
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            cnt   <= FULL_LOAD;
                            idx   <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DATA: begin
                    if (cnt == {CW{1'b0}}) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL_LOAD;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                STOP: begin
                    if (cnt == {CW{1'b0}}) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // FIFO storage and pointers; push and pop may happen on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp <= {PW{1'b0}};
            wp <= {PW{1'b0}};
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= shreg;
                wp <= wp + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rp <= rp + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with CDIV=10, BUFFER_SIZE=4.
module tb_uart_rx;

    localparam int CDIV = 10;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       ferr;
    logic       ovr;

    int errors = 0;
    int checks = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;

    uart_rx #(.CDIV(CDIV), .BUFFER_SIZE(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .ready(ready), .ferr(ferr), .ovr(ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (ferr) ferr_seen = ferr_seen + 1;
        if (ovr)  ovr_seen  = ovr_seen + 1;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CDIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (ferr !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", ferr, ovr); end
        checks++; if (dut.rp !== 3'd0 || dut.wp !== 3'd0) begin errors++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", dut.rp, dut.wp); end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_single();
        int f0;
        f0 = ferr_seen;
        send_frame(8'h67, 1'b1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", valid); end
        checks++; if (data !== 8'h67) begin errors++; $display("FAIL single_data got=%h exp=67", data); end
        idle(20);
        checks++; if (data !== 8'h67 || valid !== 1'b1) begin errors++; $display("FAIL single_hold got=%h/%b exp=67/1", data, valid); end
        checks++; if (ferr_seen != f0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", ferr_seen - f0); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", valid); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
        checks++; if (valid !== 1'b0 || dut.rp !== dut.wp) begin errors++; $display("FAIL single_pop_empty got=%b exp=0", valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        int o0;
        o0 = ovr_seen;
        for (int k = 0; k < 5; k++) send_frame(8'h61 + 8'(k), 1'b1);
        idle(10);
        checks++; if (ovr_seen - o0 != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_seen - o0); end
        for (int k = 0; k < 4; k++) begin
            exp_b = 8'h61 + 8'(k);
            checks++; if (valid !== 1'b1 || data !== exp_b) begin errors++; $display("FAIL ovr_pop%0d got=%h/%b exp=%h/1", k, data, valid, exp_b); end
            ready = 1'b1; @(negedge clk); ready = 1'b0;
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got=%b exp=0", valid); end
    endtask

    task automatic test_framing();
        int f0;
        f0 = ferr_seen;
        send_frame(8'h55, 1'b0);
        idle(20);
        checks++; if (ferr_seen - f0 != 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_seen - f0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ferr_nowrite got=%b exp=0", valid); end
        send_frame(8'h41, 1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'h41) begin errors++; $display("FAIL ferr_next got=%h/%b exp=41/1", data, valid); end
        ready = 1'b1; @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_seen;
        rx = 1'b0; repeat (3) @(negedge clk);
        idle(120);
        checks++; if (valid !== 1'b0 || dut.wp !== dut.rp) begin errors++; $display("FAIL glitch_write got=%b exp=0", valid); end
        checks++; if (ferr_seen != f0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_seen - f0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'h3C;
        rx = 1'b0; repeat (CDIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i]; repeat (CDIV) @(negedge clk);
        end
        rx = b[4]; repeat (CDIV / 2) @(negedge clk);
        rst = 1'b1; repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(60);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_write got=%b exp=0", valid); end
        send_frame(8'h7A, 1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'h7A) begin errors++; $display("FAIL midrst_next got=%h/%b exp=7a/1", data, valid); end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
